// File: rtl/hop_key_ctrl.sv
// Frog key front end: turns a held keycode into one-frame hop
// commands with auto-repeat, hop spacing, lock handling and W counting.
module hop_key_ctrl #(
  parameter int unsigned HOP_GAP       = 3,
  parameter int unsigned REPEAT_DELAY  = 20,
  parameter int unsigned REPEAT_PERIOD = 10
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic [15:0] keycode_in,
  input  logic        lock,
  output logic [15:0] keycode,
  output logic        hop_pulse,
  output logic [7:0]  hop_count
);

  localparam logic [15:0] K_W = 16'h001A;
  localparam logic [15:0] K_A = 16'h0004;
  localparam logic [15:0] K_S = 16'h0016;
  localparam logic [15:0] K_D = 16'h0007;

  localparam logic [8:0] GAP_T = 9'(HOP_GAP);
  localparam logic [8:0] DLY_T = 9'(REPEAT_DELAY);
  localparam logic [8:0] PER_T = 9'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    HOLD,
    WAIT_REL
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] key_q, key_d;
  logic [7:0]  gap_q, gap_d;
  logic        first_q, first_d;
  logic [15:0] kc_q, kc_d;
  logic        pulse_q, pulse_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [15:0] dec;
  logic [8:0]  gap_p1;
  logic [8:0]  rep_t;
  logic        issue;

  // Map both key sets onto the four canonical direction codes.
  always_comb begin
    dec = 16'h0000;
    unique case (1'b1)
      (keycode_in == 16'h001A) || (keycode_in == 16'h0075): dec = K_W;
      (keycode_in == 16'h0004) || (keycode_in == 16'h006B): dec = K_A;
      (keycode_in == 16'h0016) || (keycode_in == 16'h0072): dec = K_S;
      (keycode_in == 16'h0007) || (keycode_in == 16'h0074): dec = K_D;
      default: dec = 16'h0000;
    endcase
  end

  // Next-state, hop issue and counter update.
  always_comb begin
    gap_p1   = {1'b0, gap_q} + 9'd1;
    rep_t    = first_q ? DLY_T : PER_T;
    issue    = 1'b0;
    state_d  = state_q;
    key_d    = key_q;
    gap_d    = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;
    first_d  = first_q;
    kc_d     = 16'h0000;
    pulse_d  = 1'b0;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!lock && dec != 16'h0000 && gap_p1 >= GAP_T) begin
          issue   = 1'b1;
          first_d = 1'b1;
        end
      end
      PULSE: begin
        state_d = lock ? WAIT_REL : HOLD;
      end
      HOLD: begin
        if (lock) begin
          state_d = WAIT_REL;
        end else if (dec == 16'h0000) begin
          state_d = IDLE;
        end else if (dec == key_q) begin
          if (gap_p1 >= rep_t) begin
            issue   = 1'b1;
            first_d = 1'b0;
          end
        end else if (gap_p1 >= GAP_T) begin
          issue   = 1'b1;
          first_d = 1'b1;
        end
      end
      WAIT_REL: begin
        if (!lock && dec == 16'h0000) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      state_d = PULSE;
      key_d   = dec;
      kc_d    = dec;
      pulse_d = 1'b1;
      gap_d   = 8'd0;
      if (dec == K_W && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      key_q   <= 16'h0000;
      gap_q   <= 8'd0;
      first_q <= 1'b1;
      kc_q    <= 16'h0000;
      pulse_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      gap_q   <= gap_d;
      first_q <= first_d;
      kc_q    <= kc_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign keycode   = kc_q;
  assign hop_pulse = pulse_q;
  assign hop_count = cnt_q;

endmodule

// File: tb/tb_hop_key_ctrl.sv
// Random and directed bench for hop_key_ctrl against an
// elapsed-time model of the hop rules.
module tb_hop_key_ctrl;

  localparam int HG = 3;
  localparam int RD = 20;
  localparam int RP = 10;

  logic        frame_clk = 1'b0;
  logic        Reset_n   = 1'b1;
  logic [15:0] keycode_in = 16'h0000;
  logic        lock = 1'b0;
  logic [15:0] keycode;
  logic        hop_pulse;
  logic [7:0]  hop_count;

  hop_key_ctrl #(
    .HOP_GAP(HG), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .keycode_in(keycode_in),
    .lock      (lock),
    .keycode   (keycode),
    .hop_pulse (hop_pulse),
    .hop_count (hop_count)
  );

  always #5 frame_clk = ~frame_clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit go     = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t",
                  nm, act, exp, $time);
  endtask

  function automatic logic [15:0] dec(input logic [15:0] c);
    case (c)
      16'h001A, 16'h0075: return 16'h001A;
      16'h0004, 16'h006B: return 16'h0004;
      16'h0016, 16'h0072: return 16'h0016;
      16'h0007, 16'h0074: return 16'h0007;
      default:            return 16'h0000;
    endcase
  endfunction

  // Model: time-stamped hops; "el" is edges since the last hop edge.
  int          cyc = 0, last = 0, nrep = 0, m_cnt = 0;
  bit          busy = 0, just = 0, blocked = 0;
  logic [15:0] held = 0, exp_kc = 0;
  bit          exp_p = 0;

  always @(posedge frame_clk or negedge Reset_n) begin
    logic [15:0] k;
    int el;
    bit fire;
    if (!Reset_n) begin
      last = cyc; nrep = 0; m_cnt = 0;
      busy = 0; just = 0; blocked = 0;
      held = 0; exp_kc = 0; exp_p = 0;
    end else begin
      k = dec(keycode_in);
      cyc++;
      el = cyc - last;
      fire = 0;
      if (blocked) begin
        if (!lock && k == 0) begin blocked = 0; busy = 0; end
      end else if (just) begin
        just = 0;
        blocked = lock;
      end else if (!busy) begin
        if (!lock && k != 0 && el >= HG) begin fire = 1; nrep = 0; end
      end else if (lock) begin
        blocked = 1;
      end else if (k == 0) begin
        busy = 0;
      end else if (k == held) begin
        if (el >= ((nrep == 0) ? RD : RP)) begin fire = 1; nrep++; end
      end else if (el >= HG) begin
        fire = 1; nrep = 0;
      end
      if (fire) begin
        held = k; last = cyc; just = 1; busy = 1;
        if (k == 16'h001A && m_cnt < 255) m_cnt++;
      end
      exp_kc = fire ? k : 16'h0000;
      exp_p  = fire;
    end
  end

  int          lg_t[$];
  logic [15:0] lg_k[$];

  // Per-cycle compare against the model, plus a log of DUT hops.
  always @(negedge frame_clk) begin
    if (go) begin
      chk("keycode", int'(keycode), int'(exp_kc));
      chk("hop_pulse", int'(hop_pulse), int'(exp_p));
      chk("hop_count", int'(hop_count), m_cnt);
      chk("pulse_iff_key", int'(hop_pulse), int'(keycode != 0));
      if (hop_pulse) begin
        lg_t.push_back(cyc);
        lg_k.push_back(keycode);
      end
    end
  end

  task automatic step(input logic [15:0] k, input logic l);
    keycode_in = k;
    lock = l;
    @(posedge frame_clk);
    #2;
  endtask

  task automatic clr();
    lg_t.delete();
    lg_k.delete();
  endtask

  int          ex_t[$];
  logic [15:0] ex_k[$];

  task automatic chk_log(input string nm, input int e);
    chk({nm, "_n"}, lg_t.size(), ex_t.size());
    if (lg_t.size() == ex_t.size())
      foreach (ex_t[i]) begin
        chk({nm, "_t"}, lg_t[i] - e, ex_t[i]);
        chk({nm, "_k"}, int'(lg_k[i]), int'(ex_k[i]));
      end
    ex_t.delete();
    ex_k.delete();
  endtask

  logic [15:0] pool [11] = '{16'h0000, 16'h001A, 16'h0075, 16'h0004,
                             16'h006B, 16'h0016, 16'h0072, 16'h0007,
                             16'h0074, 16'h0099, 16'h1234};

  initial begin
    int e;
    #1 Reset_n = 1'b0;
    go = 1;
    repeat (3) @(posedge frame_clk);
    #2 Reset_n = 1'b1;
    repeat (5) step(16'h0, 1'b0);
    chk("reset_count", int'(hop_count), 0);

    // Tap
    clr(); e = cyc + 1;
    repeat (3) step(16'h0075, 1'b0);
    repeat (3) step(16'h0, 1'b0);
    ex_t.push_back(0); ex_k.push_back(16'h001A);
    chk_log("tap", e);
    chk("tap_count", int'(hop_count), 1);

    // Async reset mid-pulse
    step(16'h001A, 1'b0);
    chk("pre_rst_kc", int'(keycode), 16'h001A);
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_kc", int'(keycode), 0);
    chk("rst_p", int'(hop_pulse), 0);
    chk("rst_cnt", int'(hop_count), 0);
    @(posedge frame_clk);
    #2 Reset_n = 1'b1;
    clr();
    repeat (4) step(16'h0, 1'b0);
    chk("post_rst_kc", int'(keycode), 0);
    chk("post_rst_log", lg_t.size(), 0);

    // Hold
    clr(); e = cyc + 1;
    repeat (45) step(16'h0007, 1'b0);
    repeat (3) step(16'h0, 1'b0);
    foreach (pool[i]) if (i < 4) begin
      ex_t.push_back((i == 0) ? 0 : 10 + 10 * i);
      ex_k.push_back(16'h0007);
    end
    chk_log("hold", e);

    // Fast switch
    clr(); e = cyc + 1;
    step(16'h0004, 1'b0);
    repeat (5) step(16'h0016, 1'b0);
    repeat (3) step(16'h0, 1'b0);
    ex_t.push_back(0); ex_k.push_back(16'h0004);
    ex_t.push_back(3); ex_k.push_back(16'h0016);
    chk_log("switch", e);

    // Lock
    clr(); e = cyc + 1;
    repeat (5)  step(16'h001A, 1'b0);
    repeat (25) step(16'h001A, 1'b1);
    repeat (5)  step(16'h001A, 1'b0);
    repeat (5)  step(16'h0, 1'b0);
    step(16'h001A, 1'b0);
    repeat (3) step(16'h0, 1'b0);
    ex_t.push_back(0);  ex_k.push_back(16'h001A);
    ex_t.push_back(40); ex_k.push_back(16'h001A);
    chk_log("lock", e);
    chk("lock_count", int'(hop_count), 2);

    // Junk code
    clr();
    repeat (30) step(16'h0099, 1'b0);
    step(16'h0, 1'b0);
    chk("junk_log", lg_t.size(), 0);
    chk("junk_count", int'(hop_count), 2);

    // Saturation
    repeat (300) begin
      step(16'h001A, 1'b0);
      repeat (3) step(16'h0, 1'b0);
    end
    chk("sat_count", int'(hop_count), 255);

    // Random traffic
    repeat (250) begin
      logic [15:0] k;
      logic l;
      int n;
      k = pool[$urandom_range(0, 10)];
      l = ($urandom_range(0, 7) == 0);
      n = $urandom_range(1, 30);
      repeat (n) step(k, l);
    end
    #1 Reset_n = 1'b0;
    #2 Reset_n = 1'b1;
    repeat (100) begin
      logic [15:0] k;
      int n;
      k = pool[$urandom_range(0, 10)];
      n = $urandom_range(1, 8);
      repeat (n) step(k, ($urandom_range(0, 9) == 0));
    end

    go = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
